// File: rtl/issue_scoreboard.sv
// issue_scoreboard: registers one decoded instruction per cycle onto the issue bus,
// stalling on RAW/WAW register hazards and writeback-slot collisions.
module issue_scoreboard #(
  parameter int LAT_A = 1,
  parameter int LAT_X = 3,
  parameter int LAT_M = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [1:0]  id_is_functionalunit,
  input  logic [4:0]  id_is_rsa,
  input  logic [4:0]  id_is_rsb,
  input  logic        id_is_usea,
  input  logic        id_is_useb,
  input  logic [31:0] id_is_rega,
  input  logic [31:0] id_is_regdestv,
  input  logic [31:0] id_is_imedext,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic        id_is_readmem,
  input  logic        id_is_writemem,
  output logic        is_stall,
  output logic [1:0]  is_fu_functionalunit,
  output logic [31:0] is_fu_rega,
  output logic [31:0] is_fu_regdestv,
  output logic [31:0] is_fu_imedext,
  output logic [4:0]  is_fu_regdest,
  output logic        is_fu_writereg,
  output logic        is_fu_readmem,
  output logic        is_fu_writemem
);
  logic [3:0]  r_pend [32];
  logic [15:1] r_slot;
  logic [3:0]  w_lat;
  logic [3:0]  w_lat1;
  logic [15:0] w_slot_ext;
  logic [15:1] w_set;
  logic        w_wr;
  logic        w_hazard;
  logic        w_issue;
  logic        w_reserve;

  always_comb begin
    w_lat      = id_is_functionalunit == 2'd0 ? LAT_A[3:0] :
                 id_is_functionalunit == 2'd1 ? LAT_X[3:0] : LAT_M[3:0];
    w_lat1     = w_lat + 4'd1;
    w_slot_ext = {r_slot, 1'b0};
    w_set      = 15'(1) << (w_lat - 4'd1);
    // unit code 3 carries no writeback, so it never reserves anything
    w_wr       = id_is_writereg && id_is_functionalunit != 2'd3;
    w_hazard   = (id_is_usea && r_pend[id_is_rsa] != 4'd0) ||
                 (id_is_useb && r_pend[id_is_rsb] != 4'd0) ||
                 (w_wr && r_pend[id_is_regdest] != 4'd0) ||
                 (w_wr && w_slot_ext[w_lat1]);
    is_stall   = id_is_valid && w_hazard;
    w_issue    = id_is_valid && !w_hazard;
    w_reserve  = w_issue && w_wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_pend[i] <= 4'd0;
      r_slot <= '0;
    end else begin
      for (int i = 0; i < 32; i++)
        r_pend[i] <= (w_reserve && i != 0 && id_is_regdest == 5'(i)) ? w_lat1 :
                     (r_pend[i] != 4'd0 ? r_pend[i] - 4'd1 : 4'd0);
      r_slot <= {1'b0, r_slot[15:2]} | (w_reserve ? w_set : 15'd0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_fu_functionalunit <= 2'd3;
      is_fu_rega           <= '0;
      is_fu_regdestv       <= '0;
      is_fu_imedext        <= '0;
      is_fu_regdest        <= '0;
      is_fu_writereg       <= 1'b0;
      is_fu_readmem        <= 1'b0;
      is_fu_writemem       <= 1'b0;
    end else begin
      is_fu_functionalunit <= w_issue ? id_is_functionalunit : 2'd3;
      is_fu_rega           <= w_issue ? id_is_rega : '0;
      is_fu_regdestv       <= w_issue ? id_is_regdestv : '0;
      is_fu_imedext        <= w_issue ? id_is_imedext : '0;
      is_fu_regdest        <= w_issue ? id_is_regdest : '0;
      is_fu_writereg       <= w_issue && id_is_writereg;
      is_fu_readmem        <= w_issue && id_is_readmem;
      is_fu_writemem       <= w_issue && id_is_writemem;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: random and directed stimulus against an edge-numbered
// model of register readiness and writeback-cycle occupancy.
module tb_issue_scoreboard;
  localparam int LA = 1, LX = 3, LM = 4;
  logic        clock = 0, reset = 0;
  logic        id_is_valid = 0, id_is_usea = 0, id_is_useb = 0;
  logic [1:0]  id_is_functionalunit = 3;
  logic [4:0]  id_is_rsa = 0, id_is_rsb = 0, id_is_regdest = 0;
  logic [31:0] id_is_rega = 0, id_is_regdestv = 0, id_is_imedext = 0;
  logic        id_is_writereg = 0, id_is_readmem = 0, id_is_writemem = 0;
  logic        is_stall, is_fu_writereg, is_fu_readmem, is_fu_writemem;
  logic [1:0]  is_fu_functionalunit;
  logic [31:0] is_fu_rega, is_fu_regdestv, is_fu_imedext;
  logic [4:0]  is_fu_regdest;

  issue_scoreboard #(.LAT_A(LA), .LAT_X(LX), .LAT_M(LM)) dut (
    .clock(clock), .reset(reset), .id_is_valid(id_is_valid),
    .id_is_functionalunit(id_is_functionalunit), .id_is_rsa(id_is_rsa),
    .id_is_rsb(id_is_rsb), .id_is_usea(id_is_usea), .id_is_useb(id_is_useb),
    .id_is_rega(id_is_rega), .id_is_regdestv(id_is_regdestv),
    .id_is_imedext(id_is_imedext), .id_is_regdest(id_is_regdest),
    .id_is_writereg(id_is_writereg), .id_is_readmem(id_is_readmem),
    .id_is_writemem(id_is_writemem), .is_stall(is_stall),
    .is_fu_functionalunit(is_fu_functionalunit), .is_fu_rega(is_fu_rega),
    .is_fu_regdestv(is_fu_regdestv), .is_fu_imedext(is_fu_imedext),
    .is_fu_regdest(is_fu_regdest), .is_fu_writereg(is_fu_writereg),
    .is_fu_readmem(is_fu_readmem), .is_fu_writemem(is_fu_writemem)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, ecnt = 0, n;
  int ready_e [32];
  bit wb [int];
  bit run = 0;
  logic [1:0]  e_fu = 3;
  logic [31:0] e_a = 0, e_b = 0, e_i = 0;
  logic [4:0]  e_rd = 0;
  logic        e_wr = 0, e_rm = 0, e_wm = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat(logic [1:0] f);
    return f == 2'd0 ? LA : f == 2'd1 ? LX : LM;
  endfunction

  // an instruction issuing at edge t writes back in cycle t+L; its destination
  // may be consumed from edge t+L+2 on
  function automatic bit hz();
    int t = ecnt + 1;
    int l = lat(id_is_functionalunit);
    bit w = id_is_writereg && id_is_functionalunit != 2'd3;
    return (id_is_usea && t < ready_e[id_is_rsa]) || (id_is_useb && t < ready_e[id_is_rsb]) ||
           (w && t < ready_e[id_is_regdest]) || (w && wb.exists(t + l));
  endfunction

  function automatic void bubble();
    e_fu = 3; e_a = 0; e_b = 0; e_i = 0; e_rd = 0; e_wr = 0; e_rm = 0; e_wm = 0;
  endfunction

  function automatic void clear_model();
    foreach (ready_e[i]) ready_e[i] = 0;
    wb.delete();
    bubble();
  endfunction

  task automatic model_edge();
    bit iss = reset && id_is_valid && !hz();
    int l = lat(id_is_functionalunit);
    ecnt++;
    if (!reset) clear_model();
    else if (iss) begin
      e_fu = id_is_functionalunit; e_a = id_is_rega; e_b = id_is_regdestv; e_i = id_is_imedext;
      e_rd = id_is_regdest; e_wr = id_is_writereg; e_rm = id_is_readmem; e_wm = id_is_writemem;
      if (id_is_writereg && id_is_functionalunit != 2'd3) begin
        wb[ecnt + l] = 1;
        if (id_is_regdest != 0) ready_e[id_is_regdest] = ecnt + l + 2;
      end
    end else bubble();
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_in(bit v, logic [1:0] f, logic [4:0] a, logic [4:0] b, bit ua, bit ub,
                        logic [4:0] d, bit w, bit rm, bit wm);
    id_is_valid = v; id_is_functionalunit = f; id_is_rsa = a; id_is_rsb = b;
    id_is_usea = ua; id_is_useb = ub; id_is_regdest = d; id_is_writereg = w;
    id_is_readmem = rm; id_is_writemem = wm;
    id_is_rega = $urandom; id_is_regdestv = $urandom; id_is_imedext = $urandom;
    #1;
  endtask

  task automatic idle(int k);
    set_in(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (k) tick();
  endtask

  always @(negedge clock) if (run) begin
    chk("stall", is_stall, reset ? 32'(id_is_valid && hz()) : 0);
    chk("fu", is_fu_functionalunit, e_fu);
    chk("rega", is_fu_rega, e_a);
    chk("regdestv", is_fu_regdestv, e_b);
    chk("imedext", is_fu_imedext, e_i);
    chk("regdest", is_fu_regdest, e_rd);
    chk("writereg", is_fu_writereg, e_wr);
    chk("readmem", is_fu_readmem, e_rm);
    chk("writemem", is_fu_writemem, e_wm);
  end

  initial begin
    bit rm, wm;
    run = 1;
    repeat (2) tick();
    chk("rst0_fu", is_fu_functionalunit, 3);
    reset = 1;
    idle(3);
    // load r5 then dependent ALU: 5 stall edges
    set_in(1, 2, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_in(1, 0, 5, 0, 1, 0, 6, 1, 0, 0);
    n = 0;
    while (is_stall && n < 20) begin n++; tick(); end
    chk("lu_stalls", n, 5);
    tick();
    chk("lu_fu", is_fu_functionalunit, 0);
    chk("lu_rd", is_fu_regdest, 6);
    idle(3);
    for (int i = 1; i <= 6; i++) begin
      set_in(1, 0, 5'(9 + i), 5'(9 + i), 1, 1, 5'(i), 1, 0, 0);
      chk("ind_stall", is_stall, 0);
      tick();
      chk("ind_rd", is_fu_regdest, i);
    end
    idle(4);
    // writeback-slot collision between a load and a later ALU op
    set_in(1, 2, 0, 0, 0, 0, 7, 1, 1, 0); tick();
    idle(2);
    set_in(1, 0, 9, 0, 1, 0, 8, 1, 0, 0);
    chk("st_stall", is_stall, 1);
    tick();
    chk("st_bubble", is_fu_functionalunit, 3);
    chk("st_stall2", is_stall, 0);
    tick();
    chk("st_rd", is_fu_regdest, 8);
    idle(4);
    // store waits on MUL result r3
    set_in(1, 1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_in(1, 2, 1, 3, 1, 1, 0, 0, 0, 1);
    n = 0;
    while (is_stall && n < 20) begin n++; tick(); end
    chk("sw_stalls", n, 4);
    tick();
    chk("sw_wm", is_fu_writemem, 1);
    chk("sw_wr", is_fu_writereg, 0);
    set_in(1, 0, 11, 12, 1, 1, 12, 1, 0, 0);
    chk("sw_alu_stall", is_stall, 0);
    tick();
    chk("sw_alu_rd", is_fu_regdest, 12);
    idle(4);
    // reset discards in-flight load of r4
    set_in(1, 2, 0, 0, 0, 0, 4, 1, 1, 0); tick();
    idle(2);
    #2 reset = 0; clear_model();
    #1 chk("rst_fu", is_fu_functionalunit, 3);
    chk("rst_wr", is_fu_readmem, 0);
    tick();
    reset = 1;
    set_in(1, 0, 4, 0, 1, 0, 13, 1, 0, 0);
    chk("rst_nostall", is_stall, 0);
    tick();
    chk("rst_issue", is_fu_functionalunit, 0);
    chk("rst_rd", is_fu_regdest, 13);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(0, 3)) reset = 0; clear_model();
        repeat ($urandom_range(1, 2)) tick();
        reset = 1;
      end else begin
        if (!(id_is_valid && hz())) begin
          logic [1:0] f = 2'($urandom_range(0, 2));
          rm = f == 2 && $urandom_range(0, 1) == 1;
          wm = f == 2 && !rm && $urandom_range(0, 1) == 1;
          set_in($urandom_range(0, 9) < 8, f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 !wm && $urandom_range(0, 3) != 0, rm, wm);
        end
        tick();
      end
    end
    idle(3);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
